pipe_shifter: RTL and testbench
===============================

PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width in bits; power of two, 4 to 64.
REQ-002 SHALL have parameter SHAMT_W, default 4: shift-amount width; SHALL equal log2(WIDTH).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: request present.
REQ-006 SHALL have port in_ready, output, 1: request accepted when in_valid and in_ready are both high on a rising edge.
REQ-007 SHALL have port in_data, input, WIDTH: operand.
REQ-008 SHALL have port in_shamt, input, SHAMT_W: shift amount, 0 to WIDTH-1.
REQ-009 SHALL have port in_mode, input, 2: operation select; 00 SLL, 01 SRA, 10 ROR, 11 SRL.
REQ-010 SHALL have port out_valid, output, 1: result present.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result when out_valid and out_ready are both high.
REQ-012 SHALL have port out_data, output, WIDTH: shifted result.
REQ-013 SHALL have port out_zero, output, 1: high when out_data == 0.

Function
REQ-014 SHALL implement SHAMT_W stages; stage i shifts by 2^i when shamt bit i is set and passes data through otherwise; each stage output is registered.
REQ-015 Each stage register SHALL carry data, remaining shamt bits, mode and a valid bit.
REQ-016 SLL SHALL zero-fill from the LSB.
REQ-017 SRA SHALL replicate the operand MSB into vacated high bits.
REQ-018 ROR SHALL move bits shifted out of the LSB into the MSB.
REQ-019 SRL (new mode) SHALL zero-fill from the MSB.
REQ-020 Shift amount 0 SHALL return in_data unchanged in every mode.
REQ-021 Latency SHALL be exactly SHAMT_W cycles from acceptance to out_valid when out_ready is held high; 4 cycles at the default WIDTH.
REQ-022 Throughput SHALL be one result per cycle with out_ready held high.
REQ-023 Stall rule: stall = out_valid & ~out_ready.
REQ-024 During a stall, every stage register SHALL hold, and in_ready SHALL be low.
REQ-025 Outside a stall, in_ready SHALL be high, including while the pipe contains bubbles.
REQ-026 in_ready SHALL depend combinationally only on out_valid and out_ready, and SHALL NOT depend on in_valid.
REQ-027 Bubbles (in_valid low on an accept cycle) SHALL propagate as invalid stages; they SHALL NOT be collapsed.
REQ-028 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-029 out_data and out_zero SHALL stay stable while out_valid is high and out_ready is low.
REQ-030 out_zero SHALL be computed from the final stage data; it is meaningful only when out_valid is high.
REQ-031 Simultaneous output handshake and new input acceptance in the same cycle SHALL both complete; the pipe advances by one.

Reset
REQ-032 While rst is high at a rising edge, all stage valid bits SHALL clear, and out_valid SHALL be 0 the next cycle.
REQ-033 While rst is high at a rising edge, all stage data registers SHALL clear, so out_data is 0 and out_zero is 1.
REQ-034 in_ready SHALL be 1 in the cycle after reset.
REQ-035 Reset mid-operation SHALL discard all in-flight requests; no result from before reset SHALL appear afterwards.
REQ-036 in_valid asserted in a cycle where rst is high SHALL NOT be accepted.

Verification (WIDTH=16, out_ready=1 unless stated)
REQ-037 SLL and ROR: 0x8001 shamt 1 mode 00 -> 0x0002 on cycle 4; 0x1234 shamt 4 mode 10 -> 0x4123 on cycle 4.
REQ-038 SRA vs SRL: 0x8000 shamt 15 mode 01 -> 0xFFFF; the same operand with mode 11 -> 0x0001; out_zero 0 in both.
REQ-039 Zero and passthrough: 0x0000 shamt 7 mode 00 -> 0x0000 with out_zero=1; 0xA5A5 shamt 0, all four modes -> 0xA5A5.
REQ-040 Back-to-back with stall: issue 4 requests on consecutive cycles, then hold out_ready low for 3 cycles.
  - in_ready low for those 3 cycles.
  - out_data held stable throughout.
  - all 4 results delivered in order with no loss.
REQ-041 Bubbles: request, idle cycle, request -> outputs 4 and 6 cycles after first acceptance, out_valid low between them.
REQ-042 Reset mid-flight: accept 3 requests, assert rst 1 cycle before the first result.
  - out_valid stays 0 until a new request is accepted.
  - the new result appears exactly 4 cycles after its acceptance.

Source files
------------

// File: rtl/pipe_shifter.sv
// pipe_shifter: pipelined logarithmic shifter with valid/ready handshakes.
//   Stage i shifts by 2^i when shift-amount bit i is set, so a request takes
//   SHAMT_W cycles to reach the output. The whole pipe holds while the output
//   is valid and not accepted. Bubbles travel through the pipe as invalid
//   stages.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        request handshake
//   in_data, in_shamt        operand and shift amount (0..WIDTH-1)
//   in_mode                  00 SLL, 01 SRA, 10 ROR, 11 SRL
//   out_valid/out_ready      result handshake
//   out_data, out_zero       result and (out_data == 0) flag
module pipe_shifter #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_zero
);

   localparam int N     = SHAMT_W;
   // Stage i keeps the N-1-i shift bits it has not consumed yet. The fields
   // are packed back to back into one triangular vector so that no register
   // bit goes unused.
   localparam int REM_W = N * (N - 1) / 2;

   function automatic int rem_off(input int i);
      int o;
      o = 0;
      for (int k = 0; k < i; k++) o += N - 1 - k;
      return o;
   endfunction

   function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                 input logic [1:0] mode,
                                                 input int sh);
      case (mode)
         2'b00:   return d << sh;
         2'b01:   return $signed(d) >>> sh;
         2'b10:   return (d >> sh) | (d << (WIDTH - sh));
         default: return d >> sh;
      endcase
   endfunction

   logic [N-1:0][WIDTH-1:0] data_q, data_d;
   logic [N-1:0]            vld_q, vld_d;
   // The last stage has no shift left to do, so it carries no mode and no
   // remaining shift bits.
   logic [N-2:0][1:0]       mode_q, mode_d;
   logic [REM_W-1:0]        rem_q, rem_d;
   logic                    stall;

   assign stall    = vld_q[N-1] & ~out_ready;
   assign in_ready = ~stall;

   for (genvar i = 0; i < N; i++) begin : g_stg
      logic [WIDTH-1:0] src_data;
      logic [1:0]       src_mode;
      logic             src_vld;
      logic             src_bit;

      if (i == 0) begin : g_first
         // Stage 0 loads on every non-stall edge; in_valid low loads a bubble.
         assign src_data = in_data;
         assign src_mode = in_mode;
         assign src_vld  = in_valid;
         assign src_bit  = in_shamt[0];
         assign rem_d[N-2:0] = in_shamt[N-1:1];
      end else begin : g_next
         localparam int OFF_IN = rem_off(i - 1);
         assign src_data = data_q[i-1];
         assign src_mode = mode_q[i-1];
         assign src_vld  = vld_q[i-1];
         assign src_bit  = rem_q[OFF_IN];
         if (i < N - 1) begin : g_rem
            localparam int OFF_OUT = rem_off(i);
            assign rem_d[OFF_OUT +: N-1-i] = rem_q[OFF_IN+1 +: N-1-i];
         end
      end

      assign data_d[i] = src_bit ? shift_by(src_data, src_mode, 1 << i) : src_data;
      assign vld_d[i]  = src_vld;
      if (i < N - 1) begin : g_mode
         assign mode_d[i] = src_mode;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         vld_q  <= '0;
         mode_q <= '0;
         rem_q  <= '0;
      end else if (!stall) begin
         data_q <= data_d;
         vld_q  <= vld_d;
         mode_q <= mode_d;
         rem_q  <= rem_d;
      end
   end

   assign out_valid = vld_q[N-1];
   assign out_data  = data_q[N-1];
   assign out_zero  = (data_q[N-1] == '0);

endmodule

// File: tb/tb_pipe_shifter.sv
// tb_pipe_shifter: directed bench for pipe_shifter at WIDTH=16.
//   A vector table is streamed back to back and each result is checked on the
//   exact cycle it should appear; hand-written sequences cover stall, bubbles
//   and reset in flight.
module tb_pipe_shifter;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_shamt;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_zero;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipe_shifter #(.WIDTH(16), .SHAMT_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_zero(out_zero)
   );

   typedef struct {
      logic [15:0] data;
      logic [3:0]  shamt;
      logic [1:0]  mode;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // advance one clock; outputs are sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] s, input logic [1:0] m);
      in_valid = v;
      in_data  = d;
      in_shamt = s;
      in_mode  = m;
   endtask

   task automatic chk_out(input string name, input logic [15:0] exp);
      chk({name, ".valid"}, 32'(out_valid), 32'd1);
      chk({name, ".data"},  32'(out_data),  32'(exp));
      chk({name, ".zero"},  32'(out_zero),  32'(exp == 16'h0));
   endtask

   initial begin
      vecs[0]  = '{16'h8001, 4'd1,  2'b00, 16'h0002};
      vecs[1]  = '{16'h1234, 4'd4,  2'b10, 16'h4123};
      vecs[2]  = '{16'h8000, 4'd15, 2'b01, 16'hFFFF};
      vecs[3]  = '{16'h8000, 4'd15, 2'b11, 16'h0001};
      vecs[4]  = '{16'h0000, 4'd7,  2'b00, 16'h0000};
      vecs[5]  = '{16'hA5A5, 4'd0,  2'b00, 16'hA5A5};
      vecs[6]  = '{16'hA5A5, 4'd0,  2'b01, 16'hA5A5};
      vecs[7]  = '{16'hA5A5, 4'd0,  2'b10, 16'hA5A5};
      vecs[8]  = '{16'hA5A5, 4'd0,  2'b11, 16'hA5A5};
      vecs[9]  = '{16'h00F0, 4'd3,  2'b00, 16'h0780};
      vecs[10] = '{16'hF00F, 4'd4,  2'b01, 16'hFF00};
      vecs[11] = '{16'h0001, 4'd1,  2'b10, 16'h8000};
      vecs[12] = '{16'hF00F, 4'd8,  2'b11, 16'h00F0};
      vecs[13] = '{16'h1234, 4'd12, 2'b10, 16'h2341};
      vecs[14] = '{16'h7FFF, 4'd5,  2'b01, 16'h03FF};
      vecs[15] = '{16'h8001, 4'd15, 2'b00, 16'h8000};

      // reset state
      rst = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 16'h0, 4'd0, 2'b00);
      tick();
      tick();
      rst = 1'b0;
      chk("rst.valid", 32'(out_valid), 32'd0);
      chk("rst.data",  32'(out_data),  32'd0);
      chk("rst.zero",  32'(out_zero),  32'd1);
      chk("rst.ready", 32'(in_ready),  32'd1);

      // table streamed one per cycle: result of vecs[k] is visible after tick k+4
      for (int t = 1; t <= 16 + 3; t++) begin
         if (t <= 16) drive(1'b1, vecs[t-1].data, vecs[t-1].shamt, vecs[t-1].mode);
         else         drive(1'b0, 16'h0, 4'd0, 2'b00);
         chk($sformatf("tbl.ready%0d", t), 32'(in_ready), 32'd1);
         tick();
         if (t < 4) chk($sformatf("tbl.lat%0d", t), 32'(out_valid), 32'd0);
         else       chk_out($sformatf("tbl%0d", t - 4), vecs[t-4].exp);
      end
      drive(1'b0, 16'h0, 4'd0, 2'b00);
      tick();
      chk("tbl.drain", 32'(out_valid), 32'd0);

      // back to back then stall for 3 cycles
      drive(1'b1, 16'h0011, 4'd1, 2'b00); tick();   // -> 0022
      drive(1'b1, 16'h0100, 4'd2, 2'b11); tick();   // -> 0040
      drive(1'b1, 16'h000F, 4'd4, 2'b10); tick();   // -> F000
      drive(1'b1, 16'hC000, 4'd3, 2'b01); tick();   // -> F800
      chk_out("stl.A", 16'h0022);
      out_ready = 1'b0;
      drive(1'b1, 16'hDEAD, 4'd0, 2'b00);           // must not be taken
      #1;
      chk("stl.ready0", 32'(in_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("stl.ready%0d", k + 1), 32'(in_ready), 32'd0);
         chk_out($sformatf("stl.hold%0d", k), 16'h0022);
      end
      drive(1'b0, 16'h0, 4'd0, 2'b00);
      out_ready = 1'b1;
      #1;
      chk("stl.release", 32'(in_ready), 32'd1);
      tick(); chk_out("stl.B", 16'h0040);
      tick(); chk_out("stl.C", 16'hF000);
      tick(); chk_out("stl.D", 16'hF800);
      tick(); chk("stl.empty", 32'(out_valid), 32'd0);
      tick(); chk("stl.nojunk", 32'(out_valid), 32'd0);

      // bubble between two requests
      drive(1'b1, 16'h0003, 4'd2, 2'b00); tick();   // -> 000C
      drive(1'b0, 16'h0, 4'd0, 2'b00);
      chk("bub.ready", 32'(in_ready), 32'd1);
      tick();
      drive(1'b1, 16'h0030, 4'd4, 2'b11); tick();   // -> 0003
      drive(1'b0, 16'h0, 4'd0, 2'b00);
      chk("bub.v3", 32'(out_valid), 32'd0);
      tick(); chk_out("bub.X", 16'h000C);
      tick(); chk("bub.gap", 32'(out_valid), 32'd0);
      tick(); chk_out("bub.Y", 16'h0003);
      tick(); chk("bub.end", 32'(out_valid), 32'd0);

      // reset with 3 requests in flight, plus a request offered during reset
      drive(1'b1, 16'h1111, 4'd1, 2'b00); tick();
      drive(1'b1, 16'h2222, 4'd1, 2'b00); tick();
      drive(1'b1, 16'h3333, 4'd1, 2'b00); tick();
      drive(1'b1, 16'h4444, 4'd1, 2'b00);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b0, 16'h0, 4'd0, 2'b00);
      chk("rmf.data", 32'(out_data), 32'd0);
      chk("rmf.zero", 32'(out_zero), 32'd1);
      chk("rmf.ready", 32'(in_ready), 32'd1);
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("rmf.quiet%0d", k), 32'(out_valid), 32'd0);
         tick();
      end
      drive(1'b1, 16'h0F0F, 4'd4, 2'b00); tick();   // -> F0F0
      drive(1'b0, 16'h0, 4'd0, 2'b00);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rmf.lat%0d", k), 32'(out_valid), 32'd0);
         tick();
      end
      chk_out("rmf.new", 16'hF0F0);
      tick();
      chk("rmf.end", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
